mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_align.sv | 41 ++++
 rtl/mem_lsu.sv | 116 +++++++++++
 tb/tb_mem_lsu.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the mem_lsu load/store unit: FSM state encoding,
// access-size codes, SRAM bank geometry and the lane-offset helper.
package lsu_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int BANK_BYTES = 8192;
  localparam int BANK_AW    = $clog2(BANK_BYTES);

  // Byte offset actually used inside the word: misaligned low bits are dropped
  // so a half always sits on a half boundary and a word on lane 0.
  function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return off;
      SZ_H:    return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for mem_lsu: extracts and extends a loaded byte or
// half from the SRAM word, and merges store data into the addressed lanes.
import lsu_pkg::*;

module lsu_align (
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_signed,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{off, 3'b000} +: 8];
    half_lane = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    load_data = {{24{is_signed & byte_lane[7]}}, byte_lane};
      SZ_H:    load_data = {{16{is_signed & half_lane[15]}}, half_lane};
      default: load_data = word;
    endcase
  end

  // Sub-word stores keep the untouched lanes of the word read back from SRAM.
  always_comb begin
    merged = word;
    case (size)
      SZ_B: merged[{off, 3'b000} +: 8] = wdata[7:0];
      SZ_H: begin
        if (off[1]) merged[31:16] = wdata[15:0];
        else        merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between a CPU request port and banked word-wide SRAM.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
import lsu_pkg::*;

module mem_lsu #(
  parameter int NUM_BANKS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_en,
  output logic        mem_wen,
  output logic [2:0]  mem_cs,
  output logic [12:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  logic [1:0]         state;
  logic               we_q;
  logic               signed_q;
  logic               err_q;
  logic [1:0]         size_q;
  logic [1:0]         off_q;
  logic [2:0]         cs_q;
  logic [BANK_AW-1:0] waddr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [31:0]        load_data;
  logic [31:0]        merged;
  logic               fault;

  always_comb begin
    fault = (req_addr[31:16] != 16'h0000)
         || ({29'd0, req_addr[15:13]} >= 32'(NUM_BANKS))
         || (req_size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_size == SZ_H && req_addr[0]) || (req_size == SZ_W && req_addr[1:0] != 2'b00))
      fault = 1'b1;
`endif
  end

  // Word stores skip the read; sub-word stores read first and merge in WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= SZ_W;
      off_q    <= 2'b00;
      cs_q     <= 3'd0;
      waddr_q  <= '0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            signed_q <= req_signed;
            err_q    <= fault;
            size_q   <= req_size;
            off_q    <= lane_off(req_size, req_addr[1:0]);
            cs_q     <= req_addr[15:13];
            waddr_q  <= {req_addr[12:2], 2'b00};
            wdata_q  <= req_wdata;
            if (fault)                        state <= RESP;
            else if (req_we && req_size == SZ_W) state <= WR;
            else                              state <= RD;
          end
        end
        RD:      state <= we_q ? WR : RESP;
        WR:      state <= RESP;
        default: begin
          state <= IDLE;
          if (!we_q && !err_q) rdata_q <= load_data;
        end
      endcase
    end
  end

  lsu_align u_align (
    .size      (size_q),
    .off       (off_q),
    .is_signed (signed_q),
    .word      (mem_dout),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && err_q;
  // Load data arrives from SRAM during RESP; outside RESP the last load result is held.
  assign rsp_rdata = (state == RESP) ? ((we_q || err_q) ? 32'h0 : load_data) : rdata_q;

  assign mem_en   = (state == RD) || (state == WR);
  assign mem_wen  = (state == WR);
  assign mem_cs   = cs_q;
  assign mem_addr = waddr_q;
  assign mem_size = SZ_W;
  assign mem_din  = merged;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized self-checking bench for mem_lsu against a byte-array memory model,
// with directed transactions pinned to hand-computed values.
`timescale 1ns/1ps

module tb_mem_lsu;

  localparam int NB   = 2;
  localparam int MAXT = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_wen;
  logic [2:0]  mem_cs;
  logic [12:0] mem_addr;
  logic [1:0]  mem_size;
  logic [31:0] mem_din, mem_dout;

  always #5 clk = ~clk;

  mem_lsu #(.NUM_BANKS(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_cs(mem_cs), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'hC0FFEE11;
  endfunction

  // SRAM environment: 8 banks of 2048 words, read data one cycle after enable.
  logic [31:0] sram [0:16383];
  logic        sram_ready = 1'b0;
  always @(posedge clk) begin
    if (!sram_ready) begin
      for (int i = 0; i < 16384; i++) sram[i] <= init_word(i);
      sram_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_wen) sram[{mem_cs, mem_addr[12:2]}] <= mem_din;
      else         mem_dout <= sram[{mem_cs, mem_addr[12:2]}];
    end
  end

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Reference model and expectations, owned by the driver.
  logic [7:0]  ref_mem [0:65535];
  logic        exp_err [0:MAXT-1];
  logic        exp_access [0:MAXT-1];
  logic        exp_write [0:MAXT-1];
  logic [31:0] exp_rdata [0:MAXT-1];
  logic [31:0] exp_din [0:MAXT-1];
  logic [2:0]  exp_cs [0:MAXT-1];
  logic [12:0] exp_waddr [0:MAXT-1];
  int          exp_lat [0:MAXT-1];
  int          accept_cyc [0:MAXT-1];
  logic        lit_en [0:MAXT-1];
  logic [31:0] lit_rdata [0:MAXT-1];
  logic        lit_err [0:MAXT-1];
  int          lit_lat [0:MAXT-1];
  logic        lit_din_en [0:MAXT-1];
  logic [31:0] lit_din [0:MAXT-1];
  int          issued = 0;
  int          aborted = 0;
  logic        abort_mode = 1'b0;
  logic        pend_lit = 1'b0, pend_lit_err = 1'b0, pend_din = 1'b0;
  logic [31:0] pend_lit_rdata = 32'h0, pend_din_val = 32'h0;
  int          pend_lit_lat = 0;

  // Counters owned by the compare process.
  int done = 0;
  int tests = 0;
  int fails = 0;

  task automatic checkOutput(input string name, input int id, input logic [31:0] got, input logic [31:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      fails = fails + 1;
      $display("[TB] FAIL %s txn=%0d got=%08h expected=%08h t=%0t", name, id, got, exp, $time);
    end
  endtask

  task automatic model_predict(input int id, input logic we, input logic [31:0] addr,
                               input logic [1:0] size, input logic sgn, input logic [31:0] wdata);
    int nbytes, cs, eoff, base, wbase;
    logic flt;
    logic [31:0] v;
    cs     = int'(addr[15:13]);
    nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    flt    = (addr[31:16] != 16'h0) || (cs >= NB) || (size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if (size == 2'b01 && addr[0]) flt = 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00) flt = 1'b1;
`endif
    eoff  = (int'(addr[12:0]) / nbytes) * nbytes;
    base  = cs * 8192 + eoff;
    wbase = cs * 8192 + (int'(addr[12:0]) / 4) * 4;
    exp_err[id]    = flt;
    exp_access[id] = !flt;
    exp_write[id]  = !flt && we && !abort_mode;
    exp_cs[id]     = addr[15:13];
    exp_waddr[id]  = addr[12:0] & 13'h1FFC;
    exp_lat[id]    = flt ? 1 : (!we ? 2 : (nbytes == 4 ? 2 : 3));
    exp_rdata[id]  = 32'h0;
    exp_din[id]    = 32'h0;
    if (!flt && !we) begin
      v = 32'h0;
      for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
      if (sgn && nbytes < 4 && v[8 * nbytes - 1]) v = v | (32'hFFFFFFFF << (8 * nbytes));
      exp_rdata[id] = v;
    end
    if (!flt && we && !abort_mode) begin
      for (int i = 0; i < nbytes; i++) ref_mem[base + i] = 8'(wdata >> (8 * i));
      v = 32'h0;
      for (int i = 0; i < 4; i++) v = v | (32'(ref_mem[wbase + i]) << (8 * i));
      exp_din[id] = v;
    end
  endtask

  task automatic expectLit(input logic [31:0] rdata, input logic err, input int lat);
    pend_lit = 1'b1; pend_lit_rdata = rdata; pend_lit_err = err; pend_lit_lat = lat;
  endtask

  task automatic expectDin(input logic [31:0] din);
    pend_din = 1'b1; pend_din_val = din;
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                               input logic sgn, input logic [31:0] wdata);
    int id;
    id = issued;
    model_predict(id, we, addr, size, sgn, wdata);
    lit_en[id] = pend_lit; lit_rdata[id] = pend_lit_rdata;
    lit_err[id] = pend_lit_err; lit_lat[id] = pend_lit_lat;
    lit_din_en[id] = pend_din; lit_din[id] = pend_din_val;
    pend_lit = 1'b0; pend_din = 1'b0;
    @(negedge clk);
    req_we = we; req_addr = addr; req_size = size; req_signed = sgn; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    accept_cyc[id] = cycle;
    issued = issued + 1;
    req_valid = 1'b0;
    if (!abort_mode) begin
      for (int k = 0; k < 40 && (done + aborted) < issued; k++) @(posedge clk);
      if ((done + aborted) < issued) begin
        $display("[TB] FAIL driver_timeout txn=%0d got=no_response expected=response", id);
        $fatal(1, "[TB] response never arrived");
      end
      #1;
    end
  endtask

  // Single compare process: every negedge checks the DUT against the model.
  initial begin
    int cur, lat;
    forever begin
      @(negedge clk);
      cur = done + aborted;
      if (!rst_n) begin
        checkOutput("rst_rsp_valid", cur, 32'(rsp_valid), 32'h0);
        checkOutput("rst_rsp_err",   cur, 32'(rsp_err),   32'h0);
        checkOutput("rst_rsp_rdata", cur, rsp_rdata,      32'h0);
        checkOutput("rst_mem_en",    cur, 32'(mem_en),    32'h0);
        checkOutput("rst_mem_wen",   cur, 32'(mem_wen),   32'h0);
        checkOutput("rst_req_ready", cur, 32'(req_ready), 32'h1);
      end else if (cur >= issued) begin
        checkOutput("idle_req_ready", cur, 32'(req_ready), 32'h1);
        checkOutput("idle_rsp_valid", cur, 32'(rsp_valid), 32'h0);
        checkOutput("idle_mem_en",    cur, 32'(mem_en),    32'h0);
      end else begin
        lat = cycle - accept_cyc[cur] + 1;
        checkOutput("busy_req_ready", cur, 32'(req_ready), 32'h0);
        if (mem_en) begin
          checkOutput("mem_en_allowed", cur, 32'(exp_access[cur]), 32'h1);
          checkOutput("mem_size", cur, 32'(mem_size), 32'h2);
          checkOutput("mem_cs",   cur, 32'(mem_cs),   32'(exp_cs[cur]));
          checkOutput("mem_addr", cur, 32'(mem_addr), 32'(exp_waddr[cur]));
          if (mem_wen) begin
            checkOutput("mem_wen_allowed", cur, 32'(exp_write[cur]), 32'h1);
            checkOutput("mem_din", cur, mem_din, exp_din[cur]);
            if (lit_din_en[cur]) checkOutput("lit_mem_din", cur, mem_din, lit_din[cur]);
          end
        end
        if (rsp_valid) begin
          checkOutput("rsp_err",   cur, 32'(rsp_err), 32'(exp_err[cur]));
          checkOutput("rsp_rdata", cur, rsp_rdata,    exp_rdata[cur]);
          checkOutput("latency",   cur, 32'(lat),     32'(exp_lat[cur]));
          if (lit_en[cur]) begin
            checkOutput("lit_rdata",   cur, rsp_rdata,    lit_rdata[cur]);
            checkOutput("lit_err",     cur, 32'(rsp_err), 32'(lit_err[cur]));
            checkOutput("lit_latency", cur, 32'(lat),     32'(lit_lat[cur]));
          end
          done = done + 1;
        end else if (lat > 8) begin
          checkOutput("rsp_timeout", cur, 32'(rsp_valid), 32'h1);
          done = done + 1;
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 2'b00;
    req_signed = 1'b0; req_wdata = 32'h0;
    rst_n = 1'b0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(init_word(i / 4) >> (8 * (i % 4)));
    repeat (3) @(negedge clk);
    if (!sram_ready) begin
      $display("[TB] FAIL sram_init got=0 expected=1");
      $fatal(1, "[TB] memory model not initialised");
    end
    #2 rst_n = 1'b1;

    expectLit(32'h0, 1'b0, 2);
    applyStimulus(1'b1, 32'h0000_2004, 2'b10, 1'b0, 32'hDEADBEEF);
    expectLit(32'hDEADBEEF, 1'b0, 2);
    applyStimulus(1'b0, 32'h0000_2004, 2'b10, 1'b0, 32'h0);
    expectLit(32'h0, 1'b0, 3);
    expectDin(32'hDEA5BEEF);
    applyStimulus(1'b1, 32'h0000_2006, 2'b00, 1'b0, 32'h0000_00A5);
    expectLit(32'hFFFFFFA5, 1'b0, 2);
    applyStimulus(1'b0, 32'h0000_2006, 2'b00, 1'b1, 32'h0);
    expectLit(32'h000000A5, 1'b0, 2);
    applyStimulus(1'b0, 32'h0000_2006, 2'b00, 1'b0, 32'h0);

    applyStimulus(1'b1, 32'h0000_0000, 2'b10, 1'b0, 32'h0000_5678);
    expectLit(32'h0, 1'b0, 3);
    expectDin(32'h12345678);
    applyStimulus(1'b1, 32'h0000_0002, 2'b01, 1'b0, 32'h0000_1234);
    expectLit(32'h00001234, 1'b0, 2);
    applyStimulus(1'b0, 32'h0000_0002, 2'b01, 1'b1, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    expectLit(32'h0, 1'b1, 1);
`else
    expectLit(32'h12345678, 1'b0, 2);
`endif
    applyStimulus(1'b0, 32'h0000_0002, 2'b10, 1'b0, 32'h0);

    expectLit(32'h0, 1'b1, 1);
    applyStimulus(1'b0, 32'h0001_0000, 2'b10, 1'b0, 32'h0);
    expectLit(32'h0, 1'b1, 1);
    applyStimulus(1'b0, 32'h0000_4000, 2'b10, 1'b0, 32'h0);
    expectLit(32'h0, 1'b1, 1);
    applyStimulus(1'b1, 32'h0000_6000, 2'b00, 1'b0, 32'h0000_0055);
    expectLit(32'h0, 1'b1, 1);
    applyStimulus(1'b0, 32'h0000_0000, 2'b11, 1'b0, 32'h0);

    // Reset lands while the byte store is still in its read phase.
    abort_mode = 1'b1;
    applyStimulus(1'b1, 32'h0000_2005, 2'b00, 1'b0, 32'h0000_0077);
    #5 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 aborted = aborted + 1;
    abort_mode = 1'b0;
    #1 rst_n = 1'b1;
    expectLit(32'hDEA5BEEF, 1'b0, 2);
    applyStimulus(1'b0, 32'h0000_2004, 2'b10, 1'b0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      r  = int'($urandom_range(0, 9));
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a  = {16'h0, 3'($urandom_range(0, 2)), 13'($urandom_range(0, 31))};
      if ($urandom_range(0, 15) == 0) a[31:16] = 16'($urandom_range(1, 65535));
      applyStimulus(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom);
    end

    repeat (3) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
